// File: rtl/ram_init_port_arb.sv
// ram_init_port_arb: forwards init-sequence writes to a simple dual-port RAM,
// gates user traffic until initialisation completes, then muxes user writes
// and reads onto the registered RAM ports. Read returns travel a fixed-latency
// pipeline carrying a write-first bypass tag for same-cycle collisions.
module ram_init_port_arb #(
  parameter int DEPTH     = 32,
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int RDLAT     = 1
) (
  input  logic                 clockCore,
  input  logic                 resetCore,
  input  logic                 initDone,
  input  logic                 initEnWr,
  input  logic [ADDRWIDTH-1:0] initWrAddr,
  input  logic [DATAWIDTH-1:0] initWrData,
  input  logic                 usrWrValid,
  output logic                 usrWrReady,
  input  logic [ADDRWIDTH-1:0] usrWrAddr,
  input  logic [DATAWIDTH-1:0] usrWrData,
  input  logic                 usrRdValid,
  output logic                 usrRdReady,
  input  logic [ADDRWIDTH-1:0] usrRdAddr,
  output logic                 usrRdDataValid,
  output logic [DATAWIDTH-1:0] usrRdData,
  output logic                 ramEnWr,
  output logic [ADDRWIDTH-1:0] ramWrAddr,
  output logic [DATAWIDTH-1:0] ramWrData,
  output logic                 ramEnRd,
  output logic [ADDRWIDTH-1:0] ramRdAddr,
  input  logic [DATAWIDTH-1:0] ramRdData,
  output logic                 initBusy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Reject parameter sets the address compare or the return pipeline cannot serve.
  localparam int ADDR_MIN = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  if (ADDRWIDTH < ADDR_MIN) begin : g_bad_addrwidth
    $error("ram_init_port_arb: ADDRWIDTH too small for DEPTH");
  end
  if (RDLAT < 1 || RDLAT > 2) begin : g_bad_rdlat
    $error("ram_init_port_arb: RDLAT must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   init_busy_q, init_busy_d;
  logic   wr_rdy, rd_rdy;

  // State register; initBusy is kept as its own flop so it leaves the block registered.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      state_q     <= ST_INIT;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Next state: the level of initDone decides INIT vs RUN, including re-init.
  always_comb begin
    // NOTE: a default before any branch keeps always_comb from inferring a latch.
    state_d = state_q;
    case (state_q)
      ST_INIT: if (initDone)  state_d = ST_RUN;
      ST_RUN:  if (!initDone) state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM outputs: user readies only in RUN; init writes pre-empt the user write port.
  always_comb begin
    wr_rdy      = (state_q == ST_RUN) && !initEnWr;
    rd_rdy      = (state_q == ST_RUN);
    init_busy_d = (state_d == ST_INIT);
  end

  // ---------------------------------------------------------------------------
  // RAM port registers
  // ---------------------------------------------------------------------------
  logic                 ram_en_wr_q, ram_en_wr_d;
  logic [ADDRWIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [DATAWIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic                 ram_en_rd_q, ram_en_rd_d;
  logic [ADDRWIDTH-1:0] ram_rd_addr_q, ram_rd_addr_d;

  // Write/read mux: init write wins, else an accepted user write; payloads hold when idle.
  always_comb begin
    ram_en_wr_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    ram_en_rd_d   = 1'b0;
    ram_rd_addr_d = ram_rd_addr_q;
    if (initEnWr) begin
      ram_en_wr_d   = 1'b1;
      ram_wr_addr_d = initWrAddr;
      ram_wr_data_d = initWrData;
    end else if (usrWrValid && wr_rdy) begin
      ram_en_wr_d   = 1'b1;
      ram_wr_addr_d = usrWrAddr;
      ram_wr_data_d = usrWrData;
    end
    if (usrRdValid && rd_rdy) begin
      ram_en_rd_d   = 1'b1;
      ram_rd_addr_d = usrRdAddr;
    end
  end

  // RAM port flops.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      ram_en_wr_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      ram_en_rd_q   <= 1'b0;
      ram_rd_addr_q <= '0;
    end else begin
      ram_en_wr_q   <= ram_en_wr_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_en_rd_q   <= ram_en_rd_d;
      ram_rd_addr_q <= ram_rd_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return pipeline with collision bypass tag
  // ---------------------------------------------------------------------------
  logic                            collide;
  logic [RDLAT-1:0]                ret_vld_q, ret_vld_d;
  logic [RDLAT-1:0]                ret_byp_q, ret_byp_d;
  logic [RDLAT-1:0][DATAWIDTH-1:0] ret_data_q, ret_data_d;
  logic                            usr_rd_vld_q, usr_rd_vld_d;
  logic [DATAWIDTH-1:0]            usr_rd_data_q, usr_rd_data_d;

  // Tag the issuing read with a same-cycle write to its address, then shift RDLAT stages.
  always_comb begin
    collide       = ram_en_wr_q && ram_en_rd_q && (ram_wr_addr_q == ram_rd_addr_q);
    ret_vld_d     = ret_vld_q;
    ret_byp_d     = ret_byp_q;
    ret_data_d    = ret_data_q;
    ret_vld_d[0]  = ram_en_rd_q;
    ret_byp_d[0]  = collide;
    ret_data_d[0] = ram_wr_data_q;
    for (int i = 1; i < RDLAT; i++) begin
      ret_vld_d[i]  = ret_vld_q[i-1];
      ret_byp_d[i]  = ret_byp_q[i-1];
      ret_data_d[i] = ret_data_q[i-1];
    end
  end

  // Final return stage: bypassed write data or RAM data; data holds when no return.
  always_comb begin
    usr_rd_vld_d  = ret_vld_q[RDLAT-1];
    usr_rd_data_d = usr_rd_data_q;
    if (ret_vld_q[RDLAT-1]) begin
      usr_rd_data_d = ret_byp_q[RDLAT-1] ? ret_data_q[RDLAT-1] : ramRdData;
    end
  end

  // Return pipeline flops; reset discards in-flight reads.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      // NOTE: the tag data stages are reset too; they are a few flops, not a RAM array.
      ret_vld_q     <= '0;
      ret_byp_q     <= '0;
      ret_data_q    <= '0;
      usr_rd_vld_q  <= 1'b0;
      usr_rd_data_q <= '0;
    end else begin
      ret_vld_q     <= ret_vld_d;
      ret_byp_q     <= ret_byp_d;
      ret_data_q    <= ret_data_d;
      usr_rd_vld_q  <= usr_rd_vld_d;
      usr_rd_data_q <= usr_rd_data_d;
    end
  end

  assign usrWrReady     = wr_rdy;
  assign usrRdReady     = rd_rdy;
  assign initBusy       = init_busy_q;
  assign ramEnWr        = ram_en_wr_q;
  assign ramWrAddr      = ram_wr_addr_q;
  assign ramWrData      = ram_wr_data_q;
  assign ramEnRd        = ram_en_rd_q;
  assign ramRdAddr      = ram_rd_addr_q;
  assign usrRdDataValid = usr_rd_vld_q;
  assign usrRdData      = usr_rd_data_q;

endmodule

// File: tb/tb_ram_init_port_arb.sv
// Bench for ram_init_port_arb: two instances (RDLAT = 1 and 2) share one stimulus
// stream; each drives its own read-first RAM model. A memory-level reference
// predicts readies, RAM port contents and read returns.
module tb_ram_init_port_arb;

  logic        clockCore = 1'b0;
  logic        resetCore = 1'b0;
  logic        initDone = 1'b0, initEnWr = 1'b0;
  logic [4:0]  initWrAddr = '0, usrWrAddr = '0, usrRdAddr = '0;
  logic [31:0] initWrData = '0, usrWrData = '0;
  logic        usrWrValid = 1'b0, usrRdValid = 1'b0;

  logic        wr_rdy [2], rd_rdy [2], rd_dv [2], en_wr [2], en_rd [2], busy [2];
  logic [4:0]  wa [2], ra [2];
  logic [31:0] wd [2], rd_data [2];

  always #5 clockCore = ~clockCore;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [31:0] mem [32] = '{default: '0};
    logic [31:0] pipe [2] = '{default: '0};
    logic [31:0] rdd;

    ram_init_port_arb #(.DEPTH(32), .DATAWIDTH(32), .ADDRWIDTH(5), .RDLAT(l + 1)) u_dut (
      .clockCore(clockCore), .resetCore(resetCore), .initDone(initDone),
      .initEnWr(initEnWr), .initWrAddr(initWrAddr), .initWrData(initWrData),
      .usrWrValid(usrWrValid), .usrWrReady(wr_rdy[l]), .usrWrAddr(usrWrAddr),
      .usrWrData(usrWrData), .usrRdValid(usrRdValid), .usrRdReady(rd_rdy[l]),
      .usrRdAddr(usrRdAddr), .usrRdDataValid(rd_dv[l]), .usrRdData(rd_data[l]),
      .ramEnWr(en_wr[l]), .ramWrAddr(wa[l]), .ramWrData(wd[l]),
      .ramEnRd(en_rd[l]), .ramRdAddr(ra[l]), .ramRdData(rdd), .initBusy(busy[l])
    );

    // Read-first RAM: a read samples the old contents, data appears l+1 cycles later.
    always @(posedge clockCore) begin
      if (en_wr[l]) mem[wa[l]] <= wd[l];
      if (en_rd[l]) pipe[0] <= mem[ra[l]];
      pipe[1] <= pipe[0];
    end
    assign rdd = pipe[l];
  end

  // Reference model state
  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] ref_mem [32] = '{default: '0};
  ret_t        q0[$], q1[$];
  logic        run;
  logic [4:0]  exp_wa, exp_ra;
  logic [31:0] exp_wd;
  logic [31:0] last_d [2];
  int          cyc;
  int          n_run, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_lane(input int lane);
    logic exp_v;
    ret_t e;
    exp_v = 1'b0;
    e     = '{0, '0};
    if (lane == 0 && q0.size() > 0 && q0[0].due == cyc) begin
      exp_v = 1'b1;
      e     = q0.pop_front();
    end
    if (lane == 1 && q1.size() > 0 && q1[0].due == cyc) begin
      exp_v = 1'b1;
      e     = q1.pop_front();
    end
    if (exp_v) last_d[lane] = e.data;
    check($sformatf("lane%0d usrRdDataValid", lane), {31'd0, rd_dv[lane]}, {31'd0, exp_v});
    check($sformatf("lane%0d usrRdData", lane), rd_data[lane], last_d[lane]);
  endtask

  // One clock cycle with the inputs currently applied.
  task automatic step();
    logic        wr_rdy_e, wr_acc, rd_acc, done_s;
    logic [4:0]  a;
    logic [31:0] d;
    #1;
    wr_rdy_e = run && !initEnWr;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("lane%0d usrWrReady", l), {31'd0, wr_rdy[l]}, {31'd0, wr_rdy_e});
      check($sformatf("lane%0d usrRdReady", l), {31'd0, rd_rdy[l]}, {31'd0, run});
    end
    wr_acc = initEnWr || (usrWrValid && wr_rdy_e);
    a      = initEnWr ? initWrAddr : usrWrAddr;
    d      = initEnWr ? initWrData : usrWrData;
    if (wr_acc) begin
      ref_mem[a] = d;
      exp_wa     = a;
      exp_wd     = d;
    end
    rd_acc = usrRdValid && run;
    if (rd_acc) begin
      exp_ra = usrRdAddr;
      q0.push_back('{cyc + 3, ref_mem[usrRdAddr]});
      q1.push_back('{cyc + 4, ref_mem[usrRdAddr]});
    end
    done_s = initDone;
    @(posedge clockCore);
    #1;
    cyc++;
    run = done_s;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("lane%0d ramEnWr", l), {31'd0, en_wr[l]}, {31'd0, wr_acc});
      check($sformatf("lane%0d ramWrAddr", l), {27'd0, wa[l]}, {27'd0, exp_wa});
      check($sformatf("lane%0d ramWrData", l), wd[l], exp_wd);
      check($sformatf("lane%0d ramEnRd", l), {31'd0, en_rd[l]}, {31'd0, rd_acc});
      check($sformatf("lane%0d ramRdAddr", l), {27'd0, ra[l]}, {27'd0, exp_ra});
      check($sformatf("lane%0d initBusy", l), {31'd0, busy[l]}, {31'd0, !run});
      check_lane(l);
    end
  endtask

  task automatic do_reset();
    resetCore = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    run    = 1'b0;
    exp_wa = '0;
    exp_ra = '0;
    exp_wd = '0;
    last_d = '{default: '0};
    for (int l = 0; l < 2; l++) begin
      check($sformatf("lane%0d rst initBusy", l), {31'd0, busy[l]}, 32'd1);
      check($sformatf("lane%0d rst readies", l), {30'd0, wr_rdy[l], rd_rdy[l]}, 32'd0);
      check($sformatf("lane%0d rst enables", l), {29'd0, en_wr[l], en_rd[l], rd_dv[l]}, 32'd0);
      check($sformatf("lane%0d rst addrs", l), {22'd0, wa[l], ra[l]}, 32'd0);
      check($sformatf("lane%0d rst wrdata", l), wd[l], 32'd0);
      check($sformatf("lane%0d rst rddata", l), rd_data[l], 32'd0);
    end
    @(posedge clockCore);
    #1;
    cyc++;
    resetCore = 1'b0;
  endtask

  task automatic idle(input int n);
    usrWrValid = 1'b0;
    usrRdValid = 1'b0;
    initEnWr   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    cyc    = 0;
    run    = 1'b0;
    exp_wa = '0;
    exp_ra = '0;
    exp_wd = '0;
    last_d = '{default: '0};

    // Reset, then eight init writes while user traffic is held off.
    do_reset();
    for (int a = 0; a < 8; a++) begin
      initEnWr   = 1'b1;
      initWrAddr = 5'(a);
      initWrData = 32'hA5A5_A5A5;
      usrWrValid = 1'b1;
      usrRdValid = 1'b1;
      step();
    end
    idle(2);
    initDone = 1'b1;
    step();
    step();

    // Back-to-back reads of 0..7.
    for (int a = 0; a < 8; a++) begin
      usrRdValid = 1'b1;
      usrRdAddr  = 5'(a);
      step();
    end
    idle(5);

    // Same-cycle write and read of address 3: write-first return.
    usrWrValid = 1'b1;
    usrWrAddr  = 5'd3;
    usrWrData  = 32'h1234_5678;
    usrRdValid = 1'b1;
    usrRdAddr  = 5'd3;
    step();
    idle(5);

    // Init writes pre-empt a held user write for two cycles.
    usrWrValid = 1'b1;
    usrWrAddr  = 5'd9;
    usrWrData  = 32'hDEAD_BEEF;
    initEnWr   = 1'b1;
    initWrAddr = 5'd10;
    initWrData = 32'h1111_0000;
    step();
    initWrData = 32'h2222_0000;
    step();
    initEnWr = 1'b0;
    step();
    usrWrValid = 1'b0;
    usrRdValid = 1'b1;
    usrRdAddr  = 5'd9;
    step();
    usrRdAddr = 5'd10;
    step();
    idle(5);

    // Re-init with two reads in flight.
    usrRdValid = 1'b1;
    usrRdAddr  = 5'd3;
    step();
    usrRdAddr = 5'd9;
    initDone  = 1'b0;
    step();
    usrRdValid = 1'b1;
    usrWrValid = 1'b1;
    step();
    idle(5);
    initDone = 1'b1;
    step();

    // Reset with a read in flight: no return may follow.
    usrRdValid = 1'b1;
    usrRdAddr  = 5'd10;
    step();
    usrRdValid = 1'b0;
    initDone   = 1'b0;
    do_reset();
    idle(6);
    initDone = 1'b1;
    step();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      initEnWr   = ($urandom_range(0, 7) == 0);
      initWrAddr = 5'($urandom_range(0, 7));
      initWrData = $urandom;
      initDone   = ($urandom_range(0, 31) != 0);
      usrWrValid = $urandom_range(0, 1) == 1;
      usrWrAddr  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      usrWrData  = $urandom;
      usrRdValid = $urandom_range(0, 1) == 1;
      usrRdAddr  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      step();
    end
    idle(6);
    check("lane0 returns outstanding", q0.size(), 32'd0);
    check("lane1 returns outstanding", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
